// File: rtl/fetch_ctrl.sv
// Front-end fetch sequencer: PC redirect arbitration, imem req/ack handshake,
// single-entry instruction hand-off to decode, and stuck-fetch timeout.
module fetch_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter logic [31:0] NOP     = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trap_en,
    input  logic [31:0] trap_addr,
    input  logic        mret_en,
    input  logic [31:0] mret_addr,
    input  logic        br_en,
    input  logic [31:0] br_addr,
    input  logic        pipe_stall,
    input  logic [31:0] pc_addr,
    output logic        pc_stall,
    output logic        pc_jp_en,
    output logic [31:0] pc_jp_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        fetch_err
);

    typedef enum logic [2:0] {IDLE, REQ, HOLD, DRAIN, ERR} state_e;

    localparam logic [31:0] TLAST = TIMEOUT - 1;

    state_e      state_q;
    logic [31:0] drain_addr_q;
    logic [31:0] wait_cnt_q;
    logic        if_valid_q;
    logic [31:0] if_inst_q;
    logic [31:0] if_pc_q;
    logic        fetch_err_q;

    logic redir;
    logic tmo;

    assign redir = trap_en | mret_en | br_en;

    always_comb begin
        pc_jp_addr = br_addr;
        if (trap_en)
            pc_jp_addr = trap_addr;
        else if (mret_en)
            pc_jp_addr = mret_addr;
    end

    assign pc_jp_en = redir;
    assign pc_stall = !(redir | (state_q == REQ & imem_ack));
    assign imem_req = (state_q == REQ) | (state_q == DRAIN);

    always_comb begin
        imem_addr = 32'd0;
        if (state_q == REQ)
            imem_addr = pc_addr;
        else if (state_q == DRAIN)
            imem_addr = drain_addr_q;
    end

    // Timeout fires on the last permitted wait cycle so req is high exactly TIMEOUT cycles
    assign tmo = (TIMEOUT != 0) && imem_req && !imem_ack && (wait_cnt_q == TLAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            drain_addr_q <= 32'd0;
            wait_cnt_q   <= 32'd0;
            if_valid_q   <= 1'b0;
            if_inst_q    <= NOP;
            if_pc_q      <= 32'd0;
            fetch_err_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_q    <= REQ;
                    wait_cnt_q <= 32'd0;
                end
                REQ: begin
                    if (imem_ack) begin
                        wait_cnt_q <= 32'd0;
                        if (!redir) begin
                            if_inst_q  <= imem_rdata;
                            if_pc_q    <= pc_addr;
                            if_valid_q <= 1'b1;
                            state_q    <= HOLD;
                        end
                    end else if (redir) begin
                        drain_addr_q <= pc_addr;
                        wait_cnt_q   <= 32'd0;
                        state_q      <= DRAIN;
                    end else if (tmo) begin
                        fetch_err_q <= 1'b1;
                        state_q     <= ERR;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 32'd1;
                    end
                end
                HOLD: begin
                    if (redir) begin
                        if_valid_q <= 1'b0;
                        if_inst_q  <= NOP;
                        wait_cnt_q <= 32'd0;
                        state_q    <= REQ;
                    end else if (!pipe_stall) begin
                        if_valid_q <= 1'b0;
                        wait_cnt_q <= 32'd0;
                        state_q    <= REQ;
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        wait_cnt_q <= 32'd0;
                        state_q    <= REQ;
                    end else if (tmo) begin
                        // A redirect defers the timeout; the counter holds at its limit
                        if (!redir) begin
                            fetch_err_q <= 1'b1;
                            state_q     <= ERR;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 32'd1;
                    end
                end
                ERR: begin
                    if (redir) begin
                        fetch_err_q <= 1'b0;
                        wait_cnt_q  <= 32'd0;
                        state_q     <= REQ;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_valid  = if_valid_q;
    assign if_inst   = if_inst_q;
    assign if_pc     = if_pc_q;
    assign fetch_err = fetch_err_q;

endmodule
